// File: rtl/core_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer_pkg
// Description : Shared types and constants for the core instruction sequencer
//               (FSM state encoding, halt causes, instruction size, reset pc).
// Revision    : 1.0 - initial release
// ============================================================================
package core_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'd0,
    CAUSE_ILLEGAL    = 2'd1,
    CAUSE_TIMEOUT    = 2'd2,
    CAUSE_MISALIGNED = 2'd3
  } halt_cause_t;

  localparam logic [31:0] INSTRUCTION_BYTES = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/sequencer_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : sequencer_watchdog
// Description : Stall counter for the EXECUTE phase. Counts cycles in which the
//               ALU has not answered and flags the TIMEOUT-th such cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sequencer_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic count,
  output logic timeout
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // Stall counter: restarts on clear, saturates on the last stalled cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count && (r_count != C_LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // The current stalled cycle is the TIMEOUT-th one
  assign timeout = count && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer
// Description : Multi-cycle instruction sequencer: IDLE -> FETCH -> DECODE ->
//               EXECUTE -> WRITEBACK, with a sticky HALT on illegal opcode,
//               ALU timeout or misaligned branch target.
// Revision    : 1.0 - initial release
// ============================================================================
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned ALU_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        decode_valid,
  input  logic        illegal_instruction,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        rd_write_enable,
  output logic [31:0] retired_count,
  output logic        halted,
  output logic [1:0]  halt_cause
);

  seq_state_t  r_state;
  seq_state_t  w_state_next;
  halt_cause_t r_halt_cause;
  logic [31:0] r_pc;
  logic [31:0] r_instruction;
  logic [31:0] r_next_pc;
  logic [31:0] r_retired;
  logic        r_exec_first;
  logic        w_wd_clear;
  logic        w_wd_count;
  logic        w_wd_timeout;
  logic        w_misaligned;
  logic [31:0] w_seq_pc;

  assign w_seq_pc     = r_pc + INSTRUCTION_BYTES;
  assign w_misaligned = branch_taken && (branch_target[1:0] != 2'b00);
  assign w_wd_clear   = (r_state != ST_EXECUTE);
  assign w_wd_count   = (r_state == ST_EXECUTE) && !alu_done;

  sequencer_watchdog #(
    .TIMEOUT (ALU_TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (w_wd_clear),
    .count   (w_wd_count),
    .timeout (w_wd_timeout)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; HALT has no exit other than reset
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:      if (enable) w_state_next = ST_FETCH;
      ST_FETCH:     if (imem_ready) w_state_next = ST_DECODE;
      ST_DECODE:    w_state_next = illegal_instruction ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE: begin
        if (alu_done) begin
          w_state_next = w_misaligned ? ST_HALT : ST_WRITEBACK;
        end else if (w_wd_timeout) begin
          w_state_next = ST_HALT;
        end
      end
      ST_WRITEBACK: w_state_next = enable ? ST_FETCH : ST_IDLE;
      ST_HALT:      w_state_next = ST_HALT;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  // Strobes decoded purely from registered state
  always_comb begin
    imem_req        = 1'b0;
    decode_valid    = 1'b0;
    alu_start       = 1'b0;
    rd_write_enable = 1'b0;
    halted          = 1'b0;
    case (r_state)
      ST_FETCH:     imem_req        = 1'b1;
      ST_DECODE:    decode_valid    = 1'b1;
      ST_EXECUTE:   alu_start       = r_exec_first;
      ST_WRITEBACK: rd_write_enable = 1'b1;
      ST_HALT:      halted          = 1'b1;
      default:      ;
    endcase
  end

  // Architectural state: instruction latch, pc update, retire counter, halt cause
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc          <= RESET_PC;
      r_instruction <= '0;
      r_next_pc     <= RESET_PC;
      r_retired     <= '0;
      r_halt_cause  <= CAUSE_NONE;
      r_exec_first  <= 1'b0;
    end else begin
      // Only the cycle right after DECODE can be the first EXECUTE cycle
      r_exec_first <= (r_state == ST_DECODE);
      case (r_state)
        ST_FETCH: begin
          if (imem_ready) r_instruction <= imem_rdata;
        end
        ST_DECODE: begin
          if (illegal_instruction) r_halt_cause <= CAUSE_ILLEGAL;
        end
        ST_EXECUTE: begin
          if (alu_done) begin
            if (w_misaligned) begin
              r_halt_cause <= CAUSE_MISALIGNED;
            end else begin
              r_next_pc <= branch_taken ? branch_target : w_seq_pc;
            end
          end else if (w_wd_timeout) begin
            r_halt_cause <= CAUSE_TIMEOUT;
          end
        end
        ST_WRITEBACK: begin
          r_pc      <= r_next_pc;
          r_retired <= r_retired + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr     = r_pc;
  assign pc            = r_pc;
  assign instruction   = r_instruction;
  assign retired_count = r_retired;
  assign halt_cause    = r_halt_cause;

endmodule
`default_nettype wire

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the pc value loaded on reset.
REQ-002 Parameter ALU_TIMEOUT, default 16, SHALL be the EXECUTE cycle count after which the sequencer halts with no alu_done.
REQ-003 Ports, one per line, SHALL be:
 clock  input  1  rising-edge clock for all state.
 reset_n  input  1  asynchronous, active-low reset.
 enable  input  1  run permission, sampled in IDLE and WRITEBACK.
 imem_req  output  1  instruction fetch request.
 imem_addr  output  32  fetch address; equals pc.
 imem_ready  input  1  fetch accepted; imem_rdata valid this cycle.
 imem_rdata  input  32  fetched instruction word.
 instruction  output  32  latched instruction for decode/execute.
 pc  output  32  address of the current instruction.
 decode_valid  output  1  instruction register valid for decode (DECODE state).
 illegal_instruction  input  1  decode flag, sampled in DECODE.
 alu_start  output  1  one-cycle execute launch pulse.
 alu_done  input  1  execute result ready.
 branch_taken  input  1  redirect pc; sampled with alu_done.
 branch_target  input  32  redirect address; sampled with alu_done.
 rd_write_enable  output  1  register-file write strobe.
 retired_count  output  32  retired instruction counter.
 halted  output  1  sequencer in HALT.
 halt_cause  output  2  0 none, 1 illegal, 2 ALU timeout, 3 misaligned target.

Function
REQ-004 FSM states SHALL be IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT; one state per cycle minimum.
REQ-005 IDLE: enable=1 -> FETCH next cycle; otherwise stay.
REQ-006 FETCH: imem_req=1, imem_addr=pc; on imem_ready=1, instruction<=imem_rdata and -> DECODE; request held until accepted regardless of enable.
REQ-007 DECODE: decode_valid=1 for exactly one cycle; illegal_instruction=1 -> HALT with cause 1, else -> EXECUTE.
REQ-008 EXECUTE: alu_start=1 only in the first EXECUTE cycle; alu_done is honoured from that same cycle onward.
REQ-009 EXECUTE: a watchdog counter clears on entry and increments each cycle without alu_done; at ALU_TIMEOUT cycles -> HALT with cause 2.
REQ-010 On alu_done with branch_taken=1 and branch_target[1:0]!=0 -> HALT with cause 3, pc unchanged, no write strobe.
REQ-011 On alu_done otherwise: capture next_pc = branch_taken ? branch_target : pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0) -> WRITEBACK.
REQ-012 WRITEBACK: rd_write_enable=1 one cycle; pc<=next_pc; retired_count+1 (wraps at 2^32); enable=1 -> FETCH, else IDLE.
REQ-013 Minimum per-instruction latency SHALL be 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK) with same-cycle imem_ready and alu_done.
REQ-014 HALT SHALL be sticky until reset_n; halted=1; all strobes 0; pc, instruction, retired_count frozen.
REQ-015 imem_req, decode_valid, alu_start, rd_write_enable SHALL be registered-state decodes with no combinational path from any input.

Reset
REQ-016 reset_n low SHALL immediately force: state IDLE, pc=RESET_PC, instruction=0, retired_count=0, halt_cause=0, halted=0, all strobes 0, watchdog 0.
REQ-017 Reset asserted mid-fetch or mid-execute SHALL abandon the instruction without a write strobe or counter increment.

Structure
REQ-018 Package core_sequencer_pkg SHALL hold the state enum, halt-cause enum, INSTRUCTION_BYTES=4, and the RESET_PC default.
REQ-019 The watchdog SHALL be one sub-module, sequencer_watchdog (clear, count, timeout output).

Verification
REQ-020 Reset, enable=1, imem_ready/alu_done always 1, no branch -> pc 0,4,8 with rd_write_enable every 4th cycle; retired_count=3 after 12 cycles.
REQ-021 imem_ready delayed 3 cycles -> imem_req held 4 cycles, imem_addr stable, instruction latched only on ready cycle.
REQ-022 branch_taken=1, branch_target=32'h0000_0100 -> next imem_addr=32'h100; target 32'h102 -> halted=1, halt_cause=3, pc unchanged.
REQ-023 alu_done never asserted, ALU_TIMEOUT=16 -> HALT with cause 2 after 16 EXECUTE cycles; alu_start pulsed once.
REQ-024 illegal_instruction=1 in DECODE -> halted=1, cause 1, no alu_start; pc=32'hFFFF_FFFC non-branch -> wraps to 0.
REQ-025 reset_n low during EXECUTE -> asynchronous return to IDLE, pc=RESET_PC, retired_count unchanged at 0.
